// File: rtl/f8_clk_pkg.sv
// f8_clk_pkg: shared types and helpers for the f8 CPU clock divider controller
package f8_clk_pkg;
  localparam int DIV_W = 4;
  typedef enum logic [1:0] {RUN, STEP, HALTED} clk_state_t;
  function automatic logic div_legal(input logic [DIV_W-1:0] value, input logic [DIV_W-1:0] maxdiv);
    return (value >= DIV_W'(2)) && (value <= maxdiv);
  endfunction
endpackage

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run-time divisor, halt and single-step control for the f8 CPU clock
module clkdiv_ctrl
  import f8_clk_pkg::*;
#(
  parameter int MAXDIV = 8,
  parameter int DEFDIV = 4,
  parameter int START_HALTED = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic             clk,
  input  logic             div_valid,
  input  logic [DIV_W-1:0] div_value,
  output logic             div_ready,
  output logic             div_err,
  input  logic             halt,
  input  logic             step,
  output logic             halted,
  output logic [DIV_W-1:0] cur_div,
  output logic             tick
);
  localparam logic [DIV_W-1:0] MAX_L = DIV_W'(MAXDIV);
  localparam logic [DIV_W-1:0] DEF_L = DIV_W'(DEFDIV);
  localparam clk_state_t RST_STATE = (START_HALTED != 0) ? HALTED : RUN;
  clk_state_t       r_state, w_next;
  logic [DIV_W-1:0] r_counter, r_cur_div, r_pend_div;
  logic             r_pending, r_clk, r_div_err;
  logic             w_active, w_last, w_bound, w_accept, w_legal, w_apply;
  assign w_active  = r_state != HALTED;
  assign w_last    = r_counter == r_cur_div - DIV_W'(1);
  assign w_bound   = w_active && w_last;
  assign w_accept  = div_valid && !r_pending;
  assign w_legal   = div_legal(div_value, MAX_L);
  assign w_apply   = r_pending && (w_bound || !w_active);
  assign clk       = r_clk;
  assign div_err   = r_div_err;
  assign div_ready = !r_pending;
  assign halted    = !w_active;
  assign cur_div   = r_cur_div;
  assign tick      = w_bound;
  // next state: halts and steps only resolve at a period boundary or while halted
  always_comb begin
    w_next = r_state;
    if (r_state == HALTED) w_next = !halt ? RUN : (step ? STEP : HALTED);
    else if (w_bound && (r_state == STEP || halt)) w_next = HALTED;
  end
  // state register
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) r_state <= RST_STATE;
    else r_state <= w_next;
  // period counter, divided clock, divisor handshake and error pulse
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_counter  <= '0;
      r_cur_div  <= DEF_L;
      r_pend_div <= DEF_L;
      r_pending  <= 1'b0;
      r_clk      <= 1'b0;
      r_div_err  <= 1'b0;
    end else begin
      r_div_err <= w_accept && !w_legal;
      r_clk     <= w_active && (r_counter < (r_cur_div >> 1));
      r_counter <= (w_active && !w_last) ? r_counter + DIV_W'(1) : '0;
      if (w_apply) begin
        r_cur_div <= r_pend_div;
        r_pending <= 1'b0;
      end else if (w_accept && w_legal) begin
        r_pend_div <= div_value;
        r_pending  <= 1'b1;
      end
    end
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed bench with a period-level reference model for clkdiv_ctrl
module tb_clkdiv_ctrl;
  logic       CLK = 1'b0, RESET, div_valid, halt, step;
  logic [3:0] div_value;
  logic       clk, div_ready, div_err, halted, tick;
  logic [3:0] cur_div;
  logic       clk2, div_ready2, div_err2, halted2, tick2;
  logic [3:0] cur_div2;
  int checks = 0, errors = 0;
  bit chk_en = 0;

  clkdiv_ctrl dut (
    .CLK(CLK), .RESET(RESET), .clk(clk), .div_valid(div_valid), .div_value(div_value),
    .div_ready(div_ready), .div_err(div_err), .halt(halt), .step(step),
    .halted(halted), .cur_div(cur_div), .tick(tick)
  );

  clkdiv_ctrl #(.START_HALTED(1)) dut2 (
    .CLK(CLK), .RESET(RESET), .clk(clk2), .div_valid(1'b0), .div_value(4'd0),
    .div_ready(div_ready2), .div_err(div_err2), .halt(1'b1), .step(1'b0),
    .halted(halted2), .cur_div(cur_div2), .tick(tick2)
  );

  always #5 CLK = ~CLK;

  // reference model: mode 0 run, 1 single step, 2 halted; pos is position inside the period
  int m_mode, m_pos, m_div, m_pend;
  bit m_clk, m_err;
  bit m_acc, m_ok, m_done;
  assign m_acc  = div_valid && m_pend == 0;
  assign m_ok   = div_value >= 2 && div_value <= 8;
  assign m_done = m_mode != 2 && m_pos == m_div - 1;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_mode <= 0; m_pos <= 0; m_div <= 4; m_pend <= 0; m_clk <= 0; m_err <= 0;
    end else begin
      m_err <= m_acc && !m_ok;
      if (m_mode == 2) begin
        m_clk  <= 0;
        m_pos  <= 0;
        m_mode <= !halt ? 0 : (step ? 1 : 2);
      end else begin
        m_clk <= (2 * m_pos + 2) <= m_div;
        m_pos <= (m_pos + 1) % m_div;
        if (m_done && (m_mode == 1 || halt)) m_mode <= 2;
      end
      if (m_pend != 0 && (m_mode == 2 || m_done)) begin
        m_div  <= m_pend;
        m_pend <= 0;
      end else if (m_acc && m_ok) m_pend <= int'(div_value);
    end
  end

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  always @(negedge CLK) if (chk_en) begin
    chk("m_clk", 8'(clk), 8'(m_clk));
    chk("m_div_ready", 8'(div_ready), 8'(m_pend == 0));
    chk("m_div_err", 8'(div_err), 8'(m_err));
    chk("m_halted", 8'(halted), 8'(m_mode == 2));
    chk("m_cur_div", 8'(cur_div), 8'(m_div));
    chk("m_tick", 8'(tick), 8'(m_done));
  end

  task automatic lit(input string n, input logic [15:0] pat, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      chk(n, 8'(clk), 8'(pat[len-1-i]));
    end
  endtask

  task automatic wait_tick();
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      got = tick;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wait_tick: got 0 expected 1");
    end
  endtask

  task automatic wait_halt();
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      got = halted;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wait_halt: got 0 expected 1");
    end
  endtask

  task automatic edge2();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RESET = 0; div_valid = 0; div_value = 0; halt = 0; step = 0;
    #1 RESET = 1;
    chk_en = 1;
    #21;
    chk("rst_clk", 8'(clk), 8'd0);
    chk("rst_cur_div", 8'(cur_div), 8'd4);
    chk("rst_ready", 8'(div_ready), 8'd1);
    chk("rst_halted", 8'(halted), 8'd0);
    chk("rst_err", 8'(div_err), 8'd0);
    chk("sh_halted", 8'(halted2), 8'd1);
    chk("sh_clk", 8'(clk2), 8'd0);
    RESET = 0;
    lit("run_div4", 16'b11001100, 8);
    chk("sh_halted_run", 8'(halted2), 8'd1);
    chk("sh_clk_run", 8'(clk2), 8'd0);
    // divisor 3 offered with counter at 1
    edge2(); div_valid = 1; div_value = 3;
    edge2(); div_valid = 0;
    chk("acc3_ready", 8'(div_ready), 8'd0);
    lit("div3_switch", 16'b1001001, 7);
    chk("div3_cur", 8'(cur_div), 8'd3);
    chk("div3_ready", 8'(div_ready), 8'd1);
    // illegal divisors 9 and 1
    edge2(); div_valid = 1; div_value = 9;
    edge2(); div_valid = 0;
    chk("err9", 8'(div_err), 8'd1);
    chk("err9_ready", 8'(div_ready), 8'd1);
    edge2();
    chk("err9_clear", 8'(div_err), 8'd0);
    div_valid = 1; div_value = 1;
    edge2(); div_valid = 0;
    chk("err1", 8'(div_err), 8'd1);
    chk("err1_cur", 8'(cur_div), 8'd3);
    edge2();
    chk("err1_clear", 8'(div_err), 8'd0);
    // back to 4, then halt asserted at counter 0
    edge2(); div_valid = 1; div_value = 4;
    edge2(); div_valid = 0;
    wait_tick();
    edge2();
    chk("div4_cur", 8'(cur_div), 8'd4);
    halt = 1;
    lit("halt_period", 16'b0110000, 7);
    chk("halt_halted", 8'(halted), 8'd1);
    // single step
    edge2(); step = 1;
    edge2(); step = 0;
    lit("step_period", 16'b0110000, 7);
    chk("step_halted", 8'(halted), 8'd1);
    // resume
    edge2(); halt = 0;
    lit("resume", 16'b001100, 6);
    chk("resume_halted", 8'(halted), 8'd0);
    // divisor 2 loaded while halted
    wait_tick();
    edge2(); halt = 1;
    wait_halt();
    edge2(); div_valid = 1; div_value = 2;
    edge2(); div_valid = 0;
    chk("h2_ready", 8'(div_ready), 8'd0);
    edge2();
    chk("h2_cur", 8'(cur_div), 8'd2);
    chk("h2_ready_back", 8'(div_ready), 8'd1);
    halt = 0;
    lit("div2_run", 16'b001010, 6);
    // reset at counter 1 with a divisor pending
    wait_tick();
    edge2(); div_valid = 1; div_value = 5;
    edge2(); div_valid = 0;
    chk("prerst_clk", 8'(clk), 8'd1);
    chk("prerst_ready", 8'(div_ready), 8'd0);
    #1 RESET = 1;
    #1;
    chk("arst_clk", 8'(clk), 8'd0);
    chk("arst_ready", 8'(div_ready), 8'd1);
    chk("arst_cur", 8'(cur_div), 8'd4);
    edge2(); RESET = 0;
    lit("post_rst", 16'b01100110, 8);
    chk("post_rst_cur", 8'(cur_div), 8'd4);
    chk("sh_halted_end", 8'(halted2), 8'd1);
    chk("sh_clk_end", 8'(clk2), 8'd0);
    chk("sh_cur_end", 8'(cur_div2), 8'd4);
    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
Run-time controller for the f8 CPU clock divider. It generates the divided CPU clock `clk` from board clock `CLK` with a divisor that can be changed at run time through a valid/ready handshake. It also supports halt and single-step for debug. Divisor changes and halts take effect only at period boundaries, so `clk` never produces a runt or glitch pulse.

Parameters:
MAXDIV, 8, largest legal divisor (2..15).
DEFDIV, 4, divisor loaded at reset (2..MAXDIV).
START_HALTED, 0, when 1 the controller leaves reset in HALTED instead of RUN.

Ports:
CLK  input  1  board clock; all state updates on posedge.
RESET  input  1  asynchronous, active-high reset.
clk  output  1  divided CPU clock, registered.
div_valid  input  1  new divisor offered.
div_value  input  4  offered divisor.
div_ready  output  1  controller can accept a divisor.
div_err  output  1  one-CLK pulse: accepted divisor was illegal and discarded.
halt  input  1  level; request to stop `clk` at the next boundary.
step  input  1  level, sampled; in HALTED, run exactly one `clk` period.
halted  output  1  state == HALTED.
cur_div  output  4  divisor currently in effect.
tick  output  1  high during the last CLK cycle of each active period (counter == cur_div-1, state RUN/STEP).

Behaviour:
- Interface: one clock `CLK`; reset `RESET` is asynchronous, active-high.
- Reset values:
  - counter=0, cur_div=DEFDIV, clk=0, pending=0, div_err=0, div_ready=1.
  - state = HALTED if START_HALTED else RUN.
- States: RUN, STEP, HALTED (enum in package).
- Counter, RUN/STEP:
  - Each edge: clk <= (counter < cur_div/2), using the pre-edge counter and floor division.
  - counter wraps to 0 when counter == cur_div-1, else increments.
  - Resulting patterns: div 4 gives 1,1,0,0; div 3 gives 1,0,0; div 2 gives 1,0.
  - Latency: clk rises on the first edge after reset release when starting in RUN.
- Boundary edge = RUN/STEP edge with counter == cur_div-1. At this edge:
  - if pending: cur_div <= pend_div and pending <= 0;
  - RUN with halt=1 → HALTED;
  - STEP → HALTED unconditionally.
- HALTED:
  - counter held 0; clk <= 0.
  - halt=0 → RUN (step ignored).
  - halt=1 and step=1 → STEP.
  - Pending divisor applied on the first HALTED edge.
- step outside HALTED is ignored. A step held high re-triggers one period per return to HALTED.
- Handshake: transfer when div_valid && div_ready.
  - Legal value (2..MAXDIV): pend_div <= value, pending <= 1, div_ready=0 until the apply edge, then 1 again from the following cycle.
  - Illegal value (0, 1, >MAXDIV): transfer completes, value discarded, div_err=1 for exactly the next cycle, div_ready stays 1.
  - div_ready = !pending (combinational from the register).
- Simultaneous boundary with halt and pending divisor: both apply at the same edge; the divisor is in effect when resumed.
- Simultaneous div accept and apply edge: impossible, since div_ready=0 while pending.
- Width rules: counter and cur_div are 4 bits; cur_div/2 is a shift; no overflow since MAXDIV ≤ 15.
- Reset mid-period:
  - clk drops to 0 immediately (async).
  - Pending divisor lost.
  - cur_div returns to DEFDIV.

Decomposition:
- Package f8_clk_pkg:
  - DIV_W = 4;
  - clk_state_t enum {RUN, STEP, HALTED};
  - function div_legal(value, maxdiv).
- Single module; no sub-module needed (counter and FSM are tightly coupled). clkdiv_ctrl replaces a fixed clkdiv instance at the CPU clock root.

Test Plan:
- Reset release, defaults → clk 1,1,0,0 repeating; tick high when counter=3; cur_div=4; div_ready=1; halted=0.
- Offer div_value=3 at counter=1 → accepted, div_ready=0; clk finishes 0,0 of the current period, then 1,0,0; cur_div=3 from the boundary edge; div_ready=1 the cycle after.
- Offer div_value=9, then div_value=1 → each accepted in one cycle; div_err pulses one cycle each; cur_div unchanged; clk undisturbed.
- Assert halt at counter=0, div 4 → current period completes (1,1,0,0); halted=1; clk stays 0.
  - Pulse step for one cycle → exactly one period 1,1,0,0, then halted=1 again.
  - Deassert halt → RUN, clk resumes 1,1,0,0.
- Halted, offer div 2 → cur_div=2 on the next edge; release halt → clk 1,0 repeating.
- Assert RESET at counter=1 with a divisor pending → clk=0 asynchronously; after release cur_div=4, pending cleared, clk 1,1,0,0.
  - With START_HALTED=1 → halted=1 and clk=0 after reset.
